// File: rtl/mem_fill_ctrl_if.sv
// Cache-side request/burst bus and CPU write port of the main-memory fill controller.
interface mem_fill_ctrl_if;
   logic       REQ;
   logic [5:0] BA;
   logic [1:0] WI;
   logic       WR;
   logic [7:0] WA;
   logic [7:0] WD;
   logic       ACK;
   logic       BUSY;
   logic       MV;
   logic [7:0] MD;
   logic [1:0] LA;
   logic       DONE;

   modport master (
      output REQ, BA, WI, WR, WA, WD,
      input  ACK, BUSY, MV, MD, LA, DONE
   );

   modport slave (
      input  REQ, BA, WI, WR, WA, WD,
      output ACK, BUSY, MV, MD, LA, DONE
   );
endinterface

// File: rtl/mem_fill_ctrl.sv
// Main-memory fill controller: returns a 4-word block as a timed burst from a 256x8 array.
// Optional critical-word-first ordering is enabled by defining MEM_CWF_EN.
//
// state  | meaning
// IDLE   | waiting for REQ, BUSY low
// WAIT   | per-beat latency down-counter running
// XFER   | edge at end of this cycle loads one beat (MV/MD/LA)
// FIN    | edge at end of this cycle loads DONE and drops BUSY
module mem_fill_ctrl #(
   parameter int unsigned WAIT_CYC = 2
) (
   input logic            T2,
   input logic            CLR,
   mem_fill_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_XFER = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYC);

`ifdef MEM_CWF_EN
   localparam logic [1:0] START_MASK = 2'b11;
`else
   localparam logic [1:0] START_MASK = 2'b00;
`endif

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [5:0] ba_q, ba_d;
   logic [1:0] idx_q, idx_d;
   logic [1:0] beat_q, beat_d;
   logic       ack_q, ack_d;
   logic       busy_q, busy_d;
   logic       mv_q, mv_d;
   logic [7:0] md_q, md_d;
   logic [1:0] la_q, la_d;
   logic       done_q, done_d;
   logic [7:0] mem_q [256];
   logic [7:0] rd_data;

   // Read sees the pre-edge contents, so a same-edge write yields the old word.
   assign rd_data = mem_q[{ba_q, idx_q}];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ba_d    = ba_q;
      idx_d   = idx_q;
      beat_d  = beat_q;
      ack_d   = 1'b0;
      busy_d  = busy_q;
      mv_d    = 1'b0;
      md_d    = md_q;
      la_d    = la_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.REQ) begin
               ba_d   = bus.BA;
               idx_d  = bus.WI & START_MASK;
               beat_d = 2'd0;
               ack_d  = 1'b1;
               busy_d = 1'b1;
               if (WAIT_CYC == 0) begin
                  state_d = S_XFER;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            mv_d = 1'b1;
            md_d = rd_data;
            la_d = idx_q;
            if (beat_q == 2'd3) begin
               state_d = S_FIN;
            end else begin
               beat_d = beat_q + 2'd1;
               idx_d  = idx_q + 2'd1;
               if (WAIT_CYC == 0) begin
                  state_d = S_XFER;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         S_FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge T2) begin
      if (!CLR) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         ba_q    <= 6'd0;
         idx_q   <= 2'd0;
         beat_q  <= 2'd0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         mv_q    <= 1'b0;
         md_q    <= 8'h00;
         la_q    <= 2'd0;
         done_q  <= 1'b0;
         for (int i = 0; i < 256; i++) begin
            mem_q[i] <= 8'(i);
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ba_q    <= ba_d;
         idx_q   <= idx_d;
         beat_q  <= beat_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         mv_q    <= mv_d;
         md_q    <= md_d;
         la_q    <= la_d;
         done_q  <= done_d;
         if (bus.WR) begin
            mem_q[bus.WA] <= bus.WD;
         end
      end
   end

   assign bus.ACK  = ack_q;
   assign bus.BUSY = busy_q;
   assign bus.MV   = mv_q;
   assign bus.MD   = md_q;
   assign bus.LA   = la_q;
   assign bus.DONE = done_q;

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Bench for mem_fill_ctrl: two instances (WAIT_CYC=2 and 0) against a cycle-timeline memory model.
module tb_mem_fill_ctrl;

   logic T2  = 1'b0;
   logic CLR = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   logic [7:0] model [2][256];

   mem_fill_ctrl_if bus_w2 ();
   mem_fill_ctrl_if bus_w0 ();

   mem_fill_ctrl #(.WAIT_CYC(2)) u_w2 (.T2(T2), .CLR(CLR), .bus(bus_w2));
   mem_fill_ctrl #(.WAIT_CYC(0)) u_w0 (.T2(T2), .CLR(CLR), .bus(bus_w0));

   always #5 T2 = ~T2;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge T2);
      #1;
   endtask

   task automatic drv_req(input int sel, input logic r, input logic [5:0] ba, input logic [1:0] wi);
      if (sel == 0) begin
         bus_w2.REQ = r; bus_w2.BA = ba; bus_w2.WI = wi;
      end else begin
         bus_w0.REQ = r; bus_w0.BA = ba; bus_w0.WI = wi;
      end
   endtask

   task automatic drv_wr(input int sel, input logic wr, input logic [7:0] wa, input logic [7:0] wd);
      if (sel == 0) begin
         bus_w2.WR = wr; bus_w2.WA = wa; bus_w2.WD = wd;
      end else begin
         bus_w0.WR = wr; bus_w0.WA = wa; bus_w0.WD = wd;
      end
   endtask

   task automatic rd_out(input int sel, output logic ack, output logic busy, output logic mv,
                         output logic done, output logic [7:0] md, output logic [1:0] la);
      if (sel == 0) begin
         ack = bus_w2.ACK; busy = bus_w2.BUSY; mv = bus_w2.MV;
         done = bus_w2.DONE; md = bus_w2.MD; la = bus_w2.LA;
      end else begin
         ack = bus_w0.ACK; busy = bus_w0.BUSY; mv = bus_w0.MV;
         done = bus_w0.DONE; md = bus_w0.MD; la = bus_w0.LA;
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 256; i++)
            model[s][i] = 8'(i);
   endtask

   task automatic chk_all_zero(input int sel, input string tag);
      logic a, b, m, d;
      logic [7:0] md;
      logic [1:0] la;
      rd_out(sel, a, b, m, d, md, la);
      chk({tag, " ack"},  8'(a),  8'h00);
      chk({tag, " busy"}, 8'(b),  8'h00);
      chk({tag, " mv"},   8'(m),  8'h00);
      chk({tag, " done"}, 8'(d),  8'h00);
      chk({tag, " md"},   md,     8'h00);
      chk({tag, " la"},   8'(la), 8'h00);
   endtask

   task automatic do_reset(input string tag);
      CLR = 1'b0;
      step();
      chk_all_zero(0, {tag, " w2"});
      chk_all_zero(1, {tag, " w0"});
      CLR = 1'b1;
      model_reset();
   endtask

   // Expected timeline: accept at relative edge 0, beat k loaded at edge (k+1)(W+1),
   // DONE loaded at edge 4(W+1)+1; a write at edge e lands after any beat read at e.
   task automatic do_burst(input int sel, input logic [5:0] ba, input logic [1:0] wi,
                           input int wr_edge, input logic [7:0] wa, input logic [7:0] wd,
                           input bit hold, input string tag);
      int w, per, last, kh;
      logic [1:0] s;
      logic [7:0] exp_md [4];
      logic a, b, m, d, mv_exp;
      logic [7:0] md;
      logic [1:0] la;
      w    = (sel == 0) ? 2 : 0;
      per  = w + 1;
      last = 4 * per + 1;
`ifdef MEM_CWF_EN
      s = wi;
`else
      s = 2'd0;
`endif
      drv_req(sel, 1'b1, ba, wi);
      for (int e = 0; e <= last; e++) begin
         drv_wr(sel, e == wr_edge, wa, wd);
         for (int k = 0; k < 4; k++)
            if (e == (k + 1) * per) exp_md[k] = model[sel][{ba, 2'(s + 2'(k))}];
         if (e == wr_edge) model[sel][wa] = wd;
         step();
         if (e == 0 && !hold) drv_req(sel, 1'b0, ba, wi);
         rd_out(sel, a, b, m, d, md, la);
         mv_exp = 1'b0;
         kh = 0;
         for (int k = 0; k < 4; k++)
            if (e == (k + 1) * per) begin mv_exp = 1'b1; kh = k; end
         chk($sformatf("%s ack e%0d", tag, e),  8'(a), 8'(e == 0));
         chk($sformatf("%s mv e%0d", tag, e),   8'(m), 8'(mv_exp));
         if (mv_exp) begin
            chk($sformatf("%s md e%0d", tag, e), md, exp_md[kh]);
            chk($sformatf("%s la e%0d", tag, e), 8'(la), 8'(2'(s + 2'(kh))));
         end
         chk($sformatf("%s done e%0d", tag, e), 8'(d), 8'(e == last));
         chk($sformatf("%s busy e%0d", tag, e), 8'(b), 8'(e < last));
      end
      drv_wr(sel, 1'b0, 8'h00, 8'h00);
   endtask

   initial begin
      logic a, b, m, d;
      logic [7:0] md;
      logic [1:0] la;
      drv_req(0, 1'b0, 6'h00, 2'd0);
      drv_req(1, 1'b0, 6'h00, 2'd0);
      drv_wr(1, 1'b0, 8'h00, 8'h00);
      // Write strobe asserted during reset must not disturb the array
      drv_wr(0, 1'b1, 8'h40, 8'hEE);
      step();
      do_reset("rst0");
      drv_wr(0, 1'b0, 8'h00, 8'h00);

      do_burst(0, 6'h05, 2'd0, -1, 8'h00, 8'h00, 1'b0, "basic");
      do_burst(0, 6'h10, 2'd0, -1, 8'h00, 8'h00, 1'b0, "wr_in_rst");
      do_burst(0, 6'h05, 2'd0, 4, 8'h16, 8'hAB, 1'b0, "wr_e4");
      do_reset("rst1");
      do_burst(0, 6'h05, 2'd0, 9, 8'h16, 8'h5A, 1'b0, "wr_e9");
      do_burst(0, 6'h05, 2'd2, -1, 8'h00, 8'h00, 1'b0, "wi2");

      // Abandon a burst with reset at relative edge 7
      drv_req(0, 1'b1, 6'h05, 2'd0);
      step();
      drv_req(0, 1'b0, 6'h05, 2'd0);
      for (int i = 1; i < 7; i++) step();
      do_reset("rst_mid");
      for (int i = 0; i < 12; i++) begin
         step();
         rd_out(0, a, b, m, d, md, la);
         chk($sformatf("post_rst mv c%0d", i),   8'(m), 8'h00);
         chk($sformatf("post_rst done c%0d", i), 8'(d), 8'h00);
      end
      do_burst(0, 6'h05, 2'd0, -1, 8'h00, 8'h00, 1'b0, "restart");

      do_burst(0, 6'h03, 2'd0, -1, 8'h00, 8'h00, 1'b1, "hold1");
      do_burst(0, 6'h03, 2'd0, -1, 8'h00, 8'h00, 1'b0, "hold2");

      do_burst(1, 6'h3F, 2'd0, -1, 8'h00, 8'h00, 1'b0, "w0");
      do_burst(1, 6'h3F, 2'd1, 2, 8'hFE, 8'h77, 1'b0, "w0_wr");

      for (int it = 0; it < 10; it++) begin
         int sel, we;
         logic [5:0] ba;
         logic [7:0] wa;
         sel = int'($urandom_range(0, 1));
         ba  = 6'($urandom);
         we  = int'($urandom_range(0, 13)) - 1;
         wa  = ($urandom_range(0, 1) == 1) ? {ba, 2'($urandom)} : 8'($urandom);
         do_burst(sel, ba, 2'($urandom), we, wa, 8'($urandom), 1'b0,
                  $sformatf("rnd%0d", it));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
